// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: maps a 5-bit symbol to its rank and shifts the
// prefix-free codeword out MSB-first. Optional HUFFMAN_ENC_PARALLEL_EN adds par_code/par_len.
module huffman_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_first,
  output logic       bit_last
`ifdef HUFFMAN_ENC_PARALLEL_EN
  ,
  output logic [6:0] par_code,
  output logic [2:0] par_len
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_n;
  logic [6:0] shift, shift_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] len, len_n;

  logic [4:0] rank;
  logic [4:0] off;
  logic [6:0] code;
  logic [2:0] clen;
  logic       hs;

  always_comb begin
    rank = '0;
    case (in_data)
      5'd0:  rank = 5'd31;
      5'd1:  rank = 5'd25;
      5'd2:  rank = 5'd24;
      5'd3:  rank = 5'd23;
      5'd4:  rank = 5'd20;
      5'd5:  rank = 5'd17;
      5'd6:  rank = 5'd14;
      5'd7:  rank = 5'd10;
      5'd8:  rank = 5'd6;
      5'd9:  rank = 5'd3;
      5'd10: rank = 5'd1;
      5'd11: rank = 5'd8;
      5'd12: rank = 5'd12;
      5'd13: rank = 5'd18;
      5'd14: rank = 5'd16;
      5'd15: rank = 5'd11;
      5'd16: rank = 5'd5;
      5'd17: rank = 5'd2;
      5'd18: rank = 5'd0;
      5'd19: rank = 5'd4;
      5'd20: rank = 5'd7;
      5'd21: rank = 5'd9;
      5'd22: rank = 5'd13;
      5'd23: rank = 5'd15;
      5'd24: rank = 5'd19;
      5'd25: rank = 5'd21;
      5'd26: rank = 5'd22;
      5'd27: rank = 5'd29;
      5'd28: rank = 5'd28;
      5'd29: rank = 5'd26;
      5'd30: rank = 5'd27;
      default: rank = 5'd30;
    endcase
  end

  // codeword is left-aligned so bit 6 is always the next bit on the wire
  always_comb begin
    code = '0;
    clen = '0;
    off  = '0;
    unique case (1'b1)
      (rank < 5'd4): begin
        code = {1'b0, rank[1:0], 4'b0000};
        clen = 3'd3;
      end
      (rank >= 5'd4 && rank < 5'd12): begin
        off  = rank - 5'd4;
        code = {2'b10, off[2:0], 2'b00};
        clen = 3'd5;
      end
      (rank >= 5'd12): begin
        off  = rank - 5'd12;
        code = {2'b11, off};
        clen = 3'd7;
      end
    endcase
  end

  assign bit_valid = (state == SHIFT);
  assign bit_out   = shift[6];
  assign bit_first = bit_valid && (cnt == len);
  assign bit_last  = bit_valid && (cnt == 3'd1);
  assign in_ready  = (state == IDLE) || (bit_last && bit_ready);
  assign hs        = in_valid && in_ready;

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    len_n   = len;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_n = SHIFT;
          shift_n = code;
          cnt_n   = clen;
          len_n   = clen;
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          if (hs) begin
            shift_n = code;
            cnt_n   = clen;
            len_n   = clen;
          end else begin
            shift_n = {shift[5:0], 1'b0};
            cnt_n   = cnt - 3'd1;
            if (cnt == 3'd1) state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt   <= cnt_n;
      len   <= len_n;
    end
  end

`ifdef HUFFMAN_ENC_PARALLEL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_code <= '0;
      par_len  <= '0;
    end else if (hs) begin
      par_code <= code;
      par_len  <= clen;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: stimulus pushes expected bits,
// a negedge monitor compares every presented bit and decodes the stream.
module tb_huffman_encoder;

  logic       clk = 0;
  logic       reset = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [4:0] in_data = '0;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready = 1;
  logic       bit_first;
  logic       bit_last;
`ifdef HUFFMAN_ENC_PARALLEL_EN
  logic [6:0] par_code;
  logic [2:0] par_len;
`endif

  huffman_encoder dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .bit_first(bit_first),
    .bit_last(bit_last)
`ifdef HUFFMAN_ENC_PARALLEL_EN
    ,
    .par_code(par_code),
    .par_len(par_len)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t sb[$];
  logic stream[$];
  int   stamps[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  int fwd[32] = '{31,25,24,23,20,17,14,10,6,3,1,8,12,18,16,11,
                  5,2,0,4,7,9,13,15,19,21,22,29,28,26,27,30};
  int dec[32] = '{18,10,17,9,19,16,8,20,11,21,7,15,12,22,6,23,
                  14,5,13,24,4,25,26,3,2,1,29,30,28,27,31,0};

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          chk("bit_out", bit_out, sb[0].b);
          chk("bit_first", bit_first, sb[0].f);
          chk("bit_last", bit_last, sb[0].l);
          chk("in_ready_shift", in_ready, sb[0].l && bit_ready);
          if (bit_ready) begin
            void'(sb.pop_front());
            stream.push_back(bit_out);
            stamps.push_back(cyc);
          end
        end
      end else begin
        chk("in_ready_idle", in_ready, 1);
        chk("first_idle", bit_first, 0);
        chk("last_idle", bit_last, 0);
      end
    end
  end

  function automatic void model(input int d, output logic [6:0] c, output int n);
    int r;
    logic [4:0] o;
    r = fwd[d];
    if (r < 4) begin
      o = 5'(r);
      c = {1'b0, o[1:0], 4'b0};
      n = 3;
    end else if (r < 12) begin
      o = 5'(r - 4);
      c = {2'b10, o[2:0], 2'b0};
      n = 5;
    end else begin
      o = 5'(r - 12);
      c = {2'b11, o};
      n = 7;
    end
  endfunction

  task automatic send(input int d, input logic [6:0] c, input int n);
    int t;
    in_valid = 1;
    in_data  = 5'(d);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      for (int i = 0; i < n; i++)
        sb.push_back('{b: c[6-i], f: (i == 0), l: (i == n - 1)});
    end
    @(posedge clk);
    #1;
    in_valid = 0;
`ifdef HUFFMAN_ENC_PARALLEL_EN
    chk("par_code", par_code, c);
    chk("par_len", par_len, n);
`endif
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      t++;
      @(posedge clk);
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_bits(input int k);
    int t;
    t = 0;
    while (stream.size() < k && t < 100) begin
      t++;
      @(posedge clk);
    end
    chk("wait_bits", stream.size() >= k, 1);
  endtask

  initial begin
    int base, p, r, n;
    logic [6:0] c;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_valid", bit_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_out", bit_out, 0);
    chk("rst_first", bit_first, 0);
    chk("rst_last", bit_last, 0);
    @(posedge clk);
    #1;

    send(18, 7'b0000000, 3);
    drain();
    chk("idle_after_18", bit_valid, 0);
    send(0, 7'b1110011, 7);
    drain();
    send(7, 7'b1011000, 5);
    drain();

    base = stamps.size();
    send(18, 7'b0000000, 3);
    send(10, 7'b0010000, 3);
    drain();
    for (int i = 1; i < 6; i++)
      chk("no_gap", stamps[base+i] - stamps[base+i-1], 1);

    base = stream.size();
    send(5, 7'b1100101, 7);
    wait_bits(base + 2);
    #1;
    bit_ready = 0;
    repeat (4) @(posedge clk);
    #1;
    bit_ready = 1;
    drain();

    base = stream.size();
    send(0, 7'b1110011, 7);
    wait_bits(base + 2);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", bit_valid, 0);
    chk("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(9, 7'b0110000, 3);
    drain();

    base = stream.size();
    for (int d = 0; d < 32; d++) begin
      model(d, c, n);
      send(d, c, n);
    end
    drain();
    p = base;
    for (int d = 0; d < 32; d++) begin
      if (p + 2 >= stream.size()) begin
        chk("stream_short", p, stream.size());
        break;
      end
      if (stream[p] == 0) begin
        r = {stream[p+1], stream[p+2]};
        p += 3;
      end else if (stream[p+1] == 0) begin
        r = 4 + {stream[p+2], stream[p+3], stream[p+4]};
        p += 5;
      end else begin
        r = 12 + {stream[p+2], stream[p+3], stream[p+4],
                  stream[p+5], stream[p+6]};
        p += 7;
      end
      chk("decode", dec[r], d);
    end
    chk("stream_len", p, stream.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
# huffman_encoder

Serial Huffman encoder, the transmit end of the Huffman bitstream. Accepts one 5-bit data symbol per handshake and converts it to its frequency rank, the inverse of the decoder look-up table. It then emits the rank's prefix-free codeword MSB-first, one bit per cycle, under ready/valid flow control. It sits between the symbol source and the serial channel feeding the Huffman decoder.

## Interface
- No parameters; widths are fixed (5-bit symbols, codewords up to 7 bits).
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  encoder accepts in_data this cycle
- in_data  input  5  data symbol 0..31
- bit_out  output  1  current code bit
- bit_valid  output  1  bit_out is valid
- bit_ready  input  1  sink consumes bit_out this cycle
- bit_first  output  1  bit_out is the first bit of a codeword
- bit_last  output  1  bit_out is the last bit of a codeword

## Operation
- Data→rank map, listed for data 0..31: 31,25,24,23,20,17,14,10,6,3,1,8,12,18,16,11,5,2,0,4,7,9,13,15,19,21,22,29,28,26,27,30.
- Rank→codeword, MSB first:
  - rank 0–3: '0' + rank[1:0], 3 bits.
  - rank 4–11: '10' + (rank−4)[2:0], 5 bits.
  - rank 12–31: '11' + (rank−12)[4:0], 7 bits.
- Datapath: 7-bit shift register (codeword left-aligned), 3-bit remaining-bit counter, registered state.
- FSM IDLE: bit_valid=0, in_ready=1. An input handshake (in_valid & in_ready) loads the shift register and count, then goes to SHIFT.
- FSM SHIFT: bit_valid=1, bit_out=shift[6]. On bit_ready: shift left and decrement the count.
- On the last bit (count==1) with bit_ready:
  - if a new input handshake occurs in the same cycle, load it and stay in SHIFT;
  - otherwise go to IDLE.
- in_ready = IDLE | (SHIFT & bit_last & bit_ready). This is combinational from state and bit_ready, so no combinational path from in_valid exists.
- bit_first is high while the count equals the loaded length. bit_last is high while the count equals 1.
- Without bit_ready, bit_out, bit_first and bit_last hold stable.

## Timing
- Reset values: state IDLE, shift register 0, count 0, bit_valid=0, bit_out=0, bit_first=0, bit_last=0, in_ready=1 (the cycle after reset deasserts).
- Reset takes priority over all activity. Asserting it mid-codeword discards the remaining bits; the next cycle shows bit_valid=0.
- Latency: a handshake at edge N puts the first bit on bit_out after edge N, valid in cycle N+1.
- Throughput: with bit_ready held high and in_valid always high, one bit per cycle with no idle gap between codewords.
- A 3/5/7-bit codeword occupies exactly 3/5/7 consumed bit cycles.
- in_valid while in_ready=0: the input is not accepted. The source holds in_data.

## Configuration
- HUFFMAN_ENC_PARALLEL_EN defined: adds outputs par_code[6:0] (codeword, left-aligned, zero-padded) and par_len[2:0] (3, 5 or 7).
  - Both are registered on each input handshake.
  - Both hold until the next handshake.
  - Reset value is 0 for both.
- Undefined: these ports and registers are absent. Serial behaviour is identical in both builds.

## Test plan
- Reset, then in_data=18 with bit_ready=1 → bits 0,0,0; bit_first on bit 1, bit_last on bit 3; IDLE afterwards.
- in_data=0 (rank 31) → 1,1,1,0,0,1,1 over 7 cycles; in_data=7 (rank 10) → 1,0,1,1,0.
- Back-to-back in_data=18 then 10 with in_valid held → bits 0,0,0,0,0,1 on consecutive cycles, no gap. in_ready pulses high on the last bit of the first codeword.
- bit_ready low for 4 cycles mid-codeword of in_data=5 (rank 17, 1100101) → bit_out, bit_first and bit_last frozen; the sequence resumes intact.
- Reset asserted on the 3rd bit of in_data=0 → next cycle bit_valid=0 and in_ready=1. A following in_data=9 yields 0,1,1.
- Exhaustive: all 32 symbols. The bench's Huffman decode of the bitstream feeds the decoder table and must return the original in_data. With the macro defined, par_len/par_code match the serial bits.
